vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Display-side consumer of the text buffer. Generates VGA timing and drives the buffer read address.
- Takes the returned character code, looks up the 8x8 glyph row in an external font ROM, and emits pixel colour with aligned hsync/vsync/de.
- Sits between the text buffer read port and the board VGA pins.

Parameters:
- h_disp, 1280, visible pixels per line
- v_disp, 1024, visible lines per frame
- h_fp, 48, horizontal front porch (pixels)
- h_sync, 112, hsync width (pixels)
- h_bp, 248, horizontal back porch (pixels)
- v_fp, 1, vertical front porch (lines)
- v_sync, 3, vsync width (lines)
- v_bp, 38, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync
- FG_COLOR, 12'hFFF, RGB444 colour for glyph pixel set
- BG_COLOR, 12'h000, RGB444 colour for glyph pixel clear
- localparam addr_width = $clog2(h_disp*v_disp/64); equals 15 at defaults

Ports:
- clk  in  1  pixel clock (108 MHz at defaults)
- rst  in  1  synchronous reset, active-high
- addr_read  out  addr_width  text buffer read address, registered
- char_read  in  8  text buffer data; valid exactly 1 clk after addr_read
- font_addr  out  11  {char, glyph_row[2:0]} to font ROM, registered
- font_row  in  8  glyph row bits; valid 1 clk after font_addr; bit 7 = leftmost pixel
- vga_rgb  out  12  RGB444 pixel, registered
- vga_de  out  1  visible-region flag, registered
- vga_hsync  out  1  registered
- vga_vsync  out  1  registered
- cursor_addr  in  addr_width  cursor cell; port present only with CURSOR_EN

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = 1688 at defaults); wraps to 0.
  - v_cnt increments on the h_cnt wrap and runs 0..V_TOTAL-1 (1066); wraps to 0.
- Stage 0 timing signals, computed from the counters:
  - de0 = (h_cnt < h_disp) && (v_cnt < v_disp)
  - hs0 active when h_disp+h_fp <= h_cnt < h_disp+h_fp+h_sync, i.e. [1328,1439]
  - vs0 active when v_disp+v_fp <= v_cnt < v_disp+v_fp+v_sync, i.e. [1025,1027]
- Pipeline, with T = cycle the counters hold (h,v):
  - T+1: addr_read = (v>>3)*(h_disp/8) + (h>>3). Computed with a shift-add or constant multiply, no generic multiplier required. Width truncated to addr_width.
  - T+2: char_read valid. font_addr = {char_read, v[2:0] delayed}.
  - T+3: font_row valid.
  - T+4: vga_rgb = font_row[7 - h[2:0] delayed] ? FG_COLOR : BG_COLOR when de is delayed-high, else 12'h000.
- hsync/vsync/de are delayed 4 stages, so all outputs at T+4 describe the same (h,v). Output latency is fixed at 4 clk.
- addr_read is driven during blanking as well, with a value don't-care but in range. No read-enable exists.
- Reset:
  - h_cnt = v_cnt = 0; all pipeline registers cleared.
  - addr_read = 0, font_addr = 0, vga_rgb = 0, vga_de = 0, vga_hsync = vga_vsync = !SYNC_POL.
  - The first clk after rst deasserts has counters at (0,0).
- Reset asserted mid-frame takes effect the next clk edge: outputs go to reset values, pipeline is flushed, and there is no partial-frame resume.
- Wrap: the last visible pixel (1279,1023) maps to addr 20479. The h wrap and v wrap in the same clk move the counters to (0,0).

Optional Feature:
CURSOR_EN
- Defined:
  - A frame counter increments on each v wrap; blink = frame_cnt[5].
  - A cell whose address equals cursor_addr (compared at T+1, delayed to T+4) has glyph bits inverted when blink = 1.
  - cursor_addr port exists.
  - The frame counter resets to 0.
- Undefined: no cursor_addr port, no frame counter, rendering exactly as above.

Test Plan:
- Reset: hold rst 5 clk -> vga_rgb=0, vga_de=0, syncs=!SYNC_POL, addr_read=0. Release: first de=1 at clk 4 after release.
- Line timing: run 2 lines -> hsync period 1688 clk, active 112 clk starting 1328 clk after the de rising edge. de high 1280 clk per visible line.
- Frame timing: run 1 frame -> vsync active lines 1025..1027, frame length 1066*1688 clk, de=0 for lines 1024..1065.
- Addressing: counters at (h=8,v=16) -> addr_read=321 next clk; at (1279,1023) -> 20479; font_addr low bits = v[2:0].
- Pixel path: buffer model returns 0x41, font model returns 8'b1000_0001 -> for the cell, vga_rgb = FG at pixels 0 and 7, BG at 1..6, 4 clk after counter position.
- Mid-frame reset, plus CURSOR_EN:
  - Assert rst at (500,300) -> outputs at reset values next clk; after release the frame restarts at (0,0).
  - With CURSOR_EN, cursor_addr=0 and frame_cnt[5]=1 -> cell 0 pixels inverted.

Source files
------------

// File: rtl/vga_text_render.sv
// vga_text_render: VGA timing generator and 8x8 text-mode glyph renderer.
// Optional feature macro: CURSOR_EN adds cursor_addr and a blinking, inverted cursor cell.
// char_read and font_row are sampled on the clk edge that follows the one that
// registered addr_read / font_addr, which fixes the output latency at 4 clk.
module vga_text_render #(
  parameter int          h_disp   = 1280,
  parameter int          v_disp   = 1024,
  parameter int          h_fp     = 48,
  parameter int          h_sync   = 112,
  parameter int          h_bp     = 248,
  parameter int          v_fp     = 1,
  parameter int          v_sync   = 3,
  parameter int          v_bp     = 38,
  parameter bit          SYNC_POL = 1'b1,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000,
  localparam int         addr_width = $clog2(h_disp*v_disp/64)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [addr_width-1:0] addr_read,
  input  logic [7:0]            char_read,
  output logic [10:0]           font_addr,
  input  logic [7:0]            font_row,
  output logic [11:0]           vga_rgb,
  output logic                  vga_de,
  output logic                  vga_hsync,
  output logic                  vga_vsync
`ifdef CURSOR_EN
  ,
  input  logic [addr_width-1:0] cursor_addr
`endif
);

  localparam int H_TOTAL = h_disp + h_fp + h_sync + h_bp;
  localparam int V_TOTAL = v_disp + v_fp + v_sync + v_bp;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_C = HW'(h_disp);
  localparam logic [HW-1:0] HS_START = HW'(h_disp + h_fp);
  localparam logic [HW-1:0] HS_END   = HW'(h_disp + h_fp + h_sync);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_C = VW'(v_disp);
  localparam logic [VW-1:0] VS_START = VW'(v_disp + v_fp);
  localparam logic [VW-1:0] VS_END   = VW'(v_disp + v_fp + v_sync);

  logic [HW-1:0]           h_cnt_q, h_cnt_d;
  logic [VW-1:0]           v_cnt_q, v_cnt_d;
  logic                    h_wrap, v_wrap;
  logic                    de0, hs0, vs0, pix;
  logic [31:0]             addr_full;
  logic [addr_width-1:0]   addr_read_q, addr_read_d;
  logic [10:0]             font_addr_q, font_addr_d;
  logic [7:0]              row_q, row_d;
  logic [2:0]              vlo_q, vlo_d;
  // index 0 = registered at T+1, index 2 = registered at T+3
  logic [2:0]              de_pipe_q, de_pipe_d;
  logic [2:0]              hs_pipe_q, hs_pipe_d;
  logic [2:0]              vs_pipe_q, vs_pipe_d;
  logic [2:0][2:0]         hlo_pipe_q, hlo_pipe_d;
  logic [11:0]             vga_rgb_q, vga_rgb_d;
  logic                    vga_de_q, vga_de_d;
  logic                    vga_hsync_q, vga_hsync_d;
  logic                    vga_vsync_q, vga_vsync_d;
`ifdef CURSOR_EN
  logic [1:0]              cur_pipe_q, cur_pipe_d;
  logic [5:0]              frame_cnt_q, frame_cnt_d;
`endif

  // Raster counters: h wraps every line, v advances on the h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
  end

  // Fetch/render pipeline: address -> font lookup -> glyph row -> pixel.
  always_comb begin
    de0 = (h_cnt_q < H_DISP_C) && (v_cnt_q < V_DISP_C);
    hs0 = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs0 = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    // constant multiply by the cell columns per row; synthesis reduces it to shift-add
    addr_full   = 32'(v_cnt_q >> 3) * 32'(h_disp / 8) + 32'(h_cnt_q >> 3);
    addr_read_d = addr_full[addr_width-1:0];
    vlo_d       = v_cnt_q[2:0];
    de_pipe_d   = {de_pipe_q[1:0], de0};
    hs_pipe_d   = {hs_pipe_q[1:0], hs0};
    vs_pipe_d   = {vs_pipe_q[1:0], vs0};
    hlo_pipe_d  = {hlo_pipe_q[1:0], h_cnt_q[2:0]};
    font_addr_d = {char_read, vlo_q};
    row_d       = font_row;
    // bit 7 is the leftmost pixel, so index = 7 - h[2:0] = ~h[2:0]
    pix         = row_q[~hlo_pipe_q[2]];
`ifdef CURSOR_EN
    cur_pipe_d  = {cur_pipe_q[0], (addr_read_q == cursor_addr)};
    frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    pix         = pix ^ (cur_pipe_q[1] & frame_cnt_q[5]);
`endif
    vga_rgb_d   = de_pipe_q[2] ? (pix ? FG_COLOR : BG_COLOR) : 12'h000;
    vga_de_d    = de_pipe_q[2];
    vga_hsync_d = hs_pipe_q[2] ? SYNC_POL : ~SYNC_POL;
    vga_vsync_d = vs_pipe_q[2] ? SYNC_POL : ~SYNC_POL;
  end

  // State registers; reset flushes the pipeline and restarts the frame at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      addr_read_q <= '0;
      font_addr_q <= '0;
      row_q       <= '0;
      vlo_q       <= '0;
      de_pipe_q   <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
      hlo_pipe_q  <= '0;
      vga_rgb_q   <= '0;
      vga_de_q    <= 1'b0;
      vga_hsync_q <= ~SYNC_POL;
      vga_vsync_q <= ~SYNC_POL;
`ifdef CURSOR_EN
      cur_pipe_q  <= '0;
      frame_cnt_q <= '0;
`endif
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      addr_read_q <= addr_read_d;
      font_addr_q <= font_addr_d;
      row_q       <= row_d;
      vlo_q       <= vlo_d;
      de_pipe_q   <= de_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      hlo_pipe_q  <= hlo_pipe_d;
      vga_rgb_q   <= vga_rgb_d;
      vga_de_q    <= vga_de_d;
      vga_hsync_q <= vga_hsync_d;
      vga_vsync_q <= vga_vsync_d;
`ifdef CURSOR_EN
      cur_pipe_q  <= cur_pipe_d;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign addr_read = addr_read_q;
  assign font_addr = font_addr_q;
  assign vga_rgb   = vga_rgb_q;
  assign vga_de    = vga_de_q;
  assign vga_hsync = vga_hsync_q;
  assign vga_vsync = vga_vsync_q;

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render at a reduced raster (64x24 visible, 88x30 total)
// so whole frames fit in a short run. k = clk edges since reset release;
// outputs sampled after edge k describe raster position k-4 (addr_read: k-1,
// font_addr: k-2). Position p maps to (h,v) = (p % 88, p / 88 % 30).
module tb_vga_text_render;
  localparam int AW = $clog2(64*24/64);
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h123;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_read;
  logic [7:0]    char_read;
  logic [10:0]   font_addr;
  logic [7:0]    font_row;
  logic [11:0]   vga_rgb;
  logic          vga_de, vga_hsync, vga_vsync;
`ifdef CURSOR_EN
  logic [AW-1:0] cursor_addr = '0;
`endif

  always #5 clk = ~clk;

  // Text buffer model: cell n holds character 0x41 + n.
  assign char_read = {3'b000, addr_read} + 8'h41;
  // Font model: 'A' is 1000_0001 on every row except row 3; everything else is 0011_1100.
  assign font_row  = (font_addr[10:3] == 8'h41 && font_addr[2:0] != 3'd3) ? 8'h81 : 8'h3C;

  vga_text_render #(
    .h_disp(64), .v_disp(24), .h_fp(4), .h_sync(8), .h_bp(12),
    .v_fp(1), .v_sync(2), .v_bp(3), .SYNC_POL(1'b1),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
`ifdef CURSOR_EN
    .cursor_addr(cursor_addr),
`endif
    .clk(clk), .rst(rst),
    .addr_read(addr_read), .char_read(char_read),
    .font_addr(font_addr), .font_row(font_row),
    .vga_rgb(vga_rgb), .vga_de(vga_de),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  // kind 0: de/hs/vs/rgb, kind 1: addr_read, kind 2: font_addr
  typedef struct {
    int          k;
    int          kind;
    logic        de, hs, vs;
    logic [11:0] rgb;
    int          val;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add_o(input int k, input logic de, input logic hs, input logic vs, input logic [11:0] rgb);
    tbl.push_back('{k:k, kind:0, de:de, hs:hs, vs:vs, rgb:rgb, val:0});
  endtask

  task automatic add_v(input int k, input int kind, input int val);
    tbl.push_back('{k:k, kind:kind, de:1'b0, hs:1'b0, vs:1'b0, rgb:12'h000, val:val});
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rgb"},   int'(vga_rgb),   0);
    check({tag, "_de"},    int'(vga_de),    0);
    check({tag, "_hs"},    int'(vga_hsync), 0);
    check({tag, "_vs"},    int'(vga_vsync), 0);
    check({tag, "_addr"},  int'(addr_read), 0);
    check({tag, "_faddr"}, int'(font_addr), 0);
  endtask

  task automatic check_vec(input vec_t v);
    string s;
    s = $sformatf("k%0d", v.k);
    case (v.kind)
      0: begin
        check({s, "_de"},  int'(vga_de),    int'(v.de));
        check({s, "_hs"},  int'(vga_hsync), int'(v.hs));
        check({s, "_vs"},  int'(vga_vsync), int'(v.vs));
        check({s, "_rgb"}, int'(vga_rgb),   int'(v.rgb));
      end
      1: check({s, "_addr"},  int'(addr_read), v.val);
      default: check({s, "_faddr"}, int'(font_addr), v.val);
    endcase
  endtask

  // Clock from release up to kmax edges, applying table entries and frame-1 statistics.
  task automatic run_vectors(input int kmax);
    int   de_cnt, hs_rise;
    logic hs_prev;
    de_cnt = 0; hs_rise = 0; hs_prev = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk); #1;
      foreach (tbl[i]) if (tbl[i].k == k) check_vec(tbl[i]);
      if (k >= 4 && k <= 2643) begin
        de_cnt += int'(vga_de);
        if (vga_hsync && !hs_prev) hs_rise++;
      end
      hs_prev = vga_hsync;
      if (k == 2644) begin
        check("frame_de_count", de_cnt, 64*24);
        check("frame_hsync_pulses", hs_rise, 30);
      end
    end
  endtask

  initial begin
    // pipeline still holding reset contents, then first pixels of line 0
    add_o(3,    0, 0, 0, 12'h000);
    add_o(4,    1, 0, 0, FG);      // (0,0) 'A' bit7
    add_o(5,    1, 0, 0, BG);      // (1,0)
    add_o(11,   1, 0, 0, FG);      // (7,0) 'A' bit0
    add_o(12,   1, 0, 0, BG);      // (8,0) 'B' 3C bit7
    add_o(14,   1, 0, 0, FG);      // (10,0) 3C bit5
    add_o(67,   1, 0, 0, BG);      // (63,0) last visible pixel
    add_o(68,   0, 0, 0, 12'h000); // (64,0) blanking
    add_o(71,   0, 0, 0, 12'h000); // (67,0) just before hsync
    add_o(72,   0, 1, 0, 12'h000); // (68,0) hsync start
    add_o(79,   0, 1, 0, 12'h000); // (75,0) hsync last
    add_o(80,   0, 0, 0, 12'h000); // (76,0)
    add_o(92,   1, 0, 0, FG);      // (0,1)
    add_o(268,  1, 0, 0, BG);      // (0,3) row 3 of 'A' differs
    add_o(2091, 1, 0, 0, BG);      // (63,23) last visible pixel of frame
    add_o(2116, 0, 0, 0, 12'h000); // (0,24) first blank line
    add_o(2204, 0, 0, 1, 12'h000); // (0,25) vsync start
    add_o(2272, 0, 1, 1, 12'h000); // (68,25) hsync inside vsync
    add_o(2379, 0, 0, 1, 12'h000); // (87,26) vsync last
    add_o(2380, 0, 0, 0, 12'h000); // (0,27)
    add_o(2643, 0, 0, 0, 12'h000); // (87,29) last position of frame
    add_o(2644, 1, 0, 0, FG);      // (0,0) of next frame
    add_v(1,    1, 0);             // (0,0)
    add_v(9,    1, 1);             // (8,0)
    add_v(713,  1, 9);             // (8,8)
    add_v(2088, 1, 23);            // (63,23) last cell
    add_v(2,    2, 11'h208);       // (0,0) {0x41,0}
    add_v(266,  2, 11'h20B);       // (0,3) {0x41,3}
    add_v(714,  2, 11'h250);       // (8,8) {0x4A,0}
`ifdef CURSOR_EN
    // frame 32: blink on, cell 0 glyph inverted
    add_o(32*2640 + 4, 1, 0, 0, BG);
    add_o(32*2640 + 5, 1, 0, 0, FG);
`endif

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    run_vectors(3110);

    // mid-frame reset with counters at (30,5) of the second frame
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midreset");
    rst = 1'b0;
`ifdef CURSOR_EN
    run_vectors(32*2640 + 10);
`else
    run_vectors(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
